alu_commit_arbiter: RTL
=======================

# alu_commit_arbiter

Round-robin arbiter that shares the single register-file writeback port between N execution units (ALU0 and its siblings). Each unit holds a finished result with `valid` until the arbiter acknowledges it with a one-cycle `clear`. The arbiter captures the granted result into a one-entry output register and presents it to the writeback stage with a valid/ready handshake. It sits between the execution units' commiter interfaces and the register-file write port.

## Interface

Parameters:
- `N_UNITS`, default `core_config_pkg::ARB_UNITS` (4): number of requesting units. Range 2..8.
- `XLEN`, `REG_ADDR_W`: taken from `core_config_pkg`. They are not overridable.

Ports:
- **Clock and reset.** One clock; reset is synchronous and active-high.
  - `clk`, in, 1: the single clock.
  - `rst`, in, 1: synchronous, active-high reset.
- **Unit side.** Index `i` selects the unit.
  - `unit_valid`, in, N_UNITS: unit `i` holds a result.
  - `unit_res`, in, N_UNITS×XLEN: result data.
  - `unit_rd`, in, N_UNITS×REG_ADDR_W: destination register.
  - `unit_error`, in, N_UNITS: overflow/error flag from the unit.
  - `unit_clear`, out, N_UNITS: one-hot, one-cycle acknowledge to the granted unit.
- **Writeback side.**
  - `wb_valid`, out, 1: output register holds a packet.
  - `wb_ready`, in, 1: writeback accepts the packet this cycle.
  - `wb_data`, out, XLEN: result.
  - `wb_rd`, out, REG_ADDR_W: destination register.
  - `wb_error`, out, 1: error flag.
  - `wb_src`, out, clog2(N_UNITS): index of the unit that produced the packet.
- **Control.**
  - `flush`, in, 1: pipeline flush. Discards the output register and suppresses grants this cycle.

## Operation

- **Output register state.**
  - EMPTY (`wb_valid=0`) and FULL (`wb_valid=1`). There is no other FSM.
  - `can_load = !wb_valid || wb_ready`.
- **Grant.**
  - When `can_load && !flush && |unit_valid`, the picker selects the first valid unit at or after `rr_ptr`, searching upward with wrap N_UNITS-1→0.
  - `unit_clear[g]` is driven combinationally high that cycle.
  - At the clock edge: `{wb_data, wb_rd, wb_error, wb_src} <= {unit_res[g], unit_rd[g], unit_error[g], g}`, `wb_valid <= 1`, and `rr_ptr <= (g+1) mod N_UNITS`.
- **No grant.** If `can_load` but no unit is valid, or `flush` is high: `wb_valid <= 0` when `wb_ready` or `flush`. `rr_ptr` is unchanged.
- **Stall.** When `wb_valid && !wb_ready`, all outputs hold and `unit_clear` is all-zero. Units keep their results.
- **x0 writes.**
  - If the granted `unit_rd[g]==0` and `unit_error[g]==0`, the unit is still cleared and `rr_ptr` still advances.
  - The packet is dropped: `wb_valid` is not set.
  - A packet with `rd==0` and error set is forwarded.
- **Flush.** `flush` has priority over everything except `rst`:
  - `wb_valid <= 0`;
  - no `unit_clear`;
  - `rr_ptr` unchanged.
- **Reset values.** `wb_valid=0`, `wb_data=0`, `wb_rd=0`, `wb_error=0`, `wb_src=0`, `rr_ptr=0`. `unit_clear=0` while `rst` is high.

## Timing

- **Latency.** `unit_valid[i]` high in cycle t with the arbiter EMPTY → `unit_clear[i]` high in t → `wb_valid` high in t+1.
- **Throughput.** One packet per cycle when `wb_ready` is held high. A capture and a writeback acceptance may occur in the same cycle.
- **Unit obligation.** The unit drops `unit_valid[i]` in the cycle after its `clear`. Its own registered `clear` handling guarantees this. The arbiter does not re-check and never grants the same unit in consecutive cycles while others are valid.
- **Fairness.** Any continuously valid unit is granted within N_UNITS grants.
- **`rst` mid-transfer.** A held packet is lost and no `unit_clear` is issued. Units keep their results and are re-arbitrated from index 0 after reset.
- **`unit_clear`.** It is purely combinational from registered state, `unit_valid`, `wb_ready` and `flush`. There is no path from `unit_res`.

## Structure

- **Additions to `core_config_pkg`:**
  - `ARB_UNITS` constant;
  - `wb_packet_t` struct `{data, rd, error, src}`, used for the output register.
- **Sub-module `rr_picker`:** combinational.
  - Parameter N.
  - Inputs: `req[N]`, `ptr`.
  - Outputs: `gnt` (one-hot), `gnt_idx`, `any`.
  - Implemented as rotate, priority-encode, rotate back.
- **Top level:** the output register, the pointer register and the grant/clear gating.

## Test plan

- **Single request.** Reset, then unit 2 valid with `res=0x0000_00FF`, `rd=5`, `wb_ready=1` → `unit_clear=4'b0100` in t; `wb_valid=1`, `wb_data=0xFF`, `wb_rd=5`, `wb_src=2` in t+1.
- **Round-robin.** All 4 units valid continuously, `wb_ready=1` → `wb_src` sequence 0,1,2,3,0; one packet per cycle.
- **Backpressure.** Packet from unit 1 held with `wb_ready=0` for 3 cycles while unit 3 is valid → outputs stable, `unit_clear=0`. When `wb_ready=1`, unit 3 is captured the same cycle and `wb_src=3` the next cycle.
- **x0 drop.** Unit 0 valid with `rd=0`, `error=0` → `unit_clear[0]` pulses, `wb_valid` stays 0, next grant starts at unit 1. Repeat with `error=1` → packet forwarded with `wb_error=1`.
- **Flush.** `flush` asserted with the output FULL and unit 2 valid → `wb_valid=0` next cycle, no `unit_clear`. Unit 2 is granted the cycle after `flush` drops.
- **Reset mid-stall.** `rst` for 1 cycle with FULL output and units 1 and 3 valid → all outputs 0. After release, unit 1 is granted first.

Source files
------------

// File: rtl/core_config_pkg.sv
// Core-wide configuration: datapath widths, commit-arbiter sizing and the
// writeback packet layout shared by the commit arbiter and its users.
package core_config_pkg;
   localparam int XLEN       = 32;
   localparam int REG_ADDR_W = 5;
   localparam int ARB_UNITS  = 4;
   // Source index field is sized for the largest supported arbiter (8 units).
   localparam int SRC_MAX_W  = 3;

   typedef struct packed {
      logic [XLEN-1:0]       data;
      logic [REG_ADDR_W-1:0] rd;
      logic                  error;
      logic [SRC_MAX_W-1:0]  src;
   } wb_packet_t;

   typedef enum logic {
      OUT_EMPTY = 1'b0,
      OUT_FULL  = 1'b1
   } out_state_e;
endpackage

// File: rtl/alu_commit_arbiter_if.sv
// Bundle between the execution units, the commit arbiter and the writeback
// stage; slave is the arbiter's view, master the units/writeback view.
interface alu_commit_arbiter_if
   import core_config_pkg::*;
#(
   parameter int N_UNITS = ARB_UNITS
) ();
   localparam int SRC_W = $clog2(N_UNITS);

   logic [N_UNITS-1:0]                 unit_valid;
   logic [N_UNITS-1:0][XLEN-1:0]       unit_res;
   logic [N_UNITS-1:0][REG_ADDR_W-1:0] unit_rd;
   logic [N_UNITS-1:0]                 unit_error;
   logic [N_UNITS-1:0]                 unit_clear;
   logic                               wb_valid;
   logic                               wb_ready;
   logic [XLEN-1:0]                    wb_data;
   logic [REG_ADDR_W-1:0]              wb_rd;
   logic                               wb_error;
   logic [SRC_W-1:0]                   wb_src;
   logic                               flush;

   modport slave (
      input  unit_valid, unit_res, unit_rd, unit_error, wb_ready, flush,
      output unit_clear, wb_valid, wb_data, wb_rd, wb_error, wb_src
   );

   modport master (
      output unit_valid, unit_res, unit_rd, unit_error, wb_ready, flush,
      input  unit_clear, wb_valid, wb_data, wb_rd, wb_error, wb_src
   );
endinterface

// File: rtl/alu_commit_arbiter_rr_picker.sv
// Combinational round-robin picker: rotate requests so ptr is bit 0,
// take the lowest set bit, then rotate the index back.
module rr_picker #(
   parameter  int N  = 4,
   localparam int IW = $clog2(N)
) (
   input  logic [N-1:0]  req_i,
   input  logic [IW-1:0] ptr_i,
   output logic [N-1:0]  gnt_o,
   output logic [IW-1:0] gnt_idx_o,
   output logic          any_o
);
   logic [N-1:0]  req_rot;
   logic [IW-1:0] rot_idx;
   logic [IW:0]   pos;
   logic [IW:0]   sum;

   always_comb begin
      req_rot = '0;
      pos     = '0;
      for (int k = 0; k < N; k++) begin
         pos = (IW+1)'(k) + {1'b0, ptr_i};
         if (pos >= (IW+1)'(N)) pos = pos - (IW+1)'(N);
         req_rot[k] = req_i[pos[IW-1:0]];
      end
   end

   always_comb begin
      rot_idx = '0;
      any_o   = 1'b0;
      for (int k = N - 1; k >= 0; k--) begin
         if (req_rot[k]) begin
            rot_idx = IW'(k);
            any_o   = 1'b1;
         end
      end
   end

   always_comb begin
      sum = {1'b0, rot_idx} + {1'b0, ptr_i};
      if (sum >= (IW+1)'(N)) sum = sum - (IW+1)'(N);
      gnt_idx_o = sum[IW-1:0];
      gnt_o     = any_o ? (N'(1) << gnt_idx_o) : '0;
   end
endmodule

// File: rtl/alu_commit_arbiter.sv
// Shares the register-file writeback port between N execution units using a
// round-robin grant and a one-entry output register.
module alu_commit_arbiter
   import core_config_pkg::*;
#(
   parameter int N_UNITS = ARB_UNITS
) (
   input  logic                  clk,
   input  logic                  rst,
   alu_commit_arbiter_if.slave   bus,
   output out_state_e            dbg_state_o
);
   localparam int SRC_W = $clog2(N_UNITS);

   // Handshakes: a unit offers a result by holding unit_valid; the one-cycle
   // unit_clear is its acknowledge. The output register offers a packet with
   // wb_valid and it is consumed in any cycle where wb_valid && wb_ready.
   out_state_e       state_q, state_d;
   wb_packet_t       pkt_q, pkt_d;
   logic [SRC_W-1:0] ptr_q, ptr_d;

   logic [N_UNITS-1:0] gnt;
   logic [SRC_W-1:0]   gnt_idx;
   logic               any_req;
   logic               can_load;
   logic               grant;
   logic               drop;

   rr_picker #(.N(N_UNITS)) u_picker (
      .req_i     (bus.unit_valid),
      .ptr_i     (ptr_q),
      .gnt_o     (gnt),
      .gnt_idx_o (gnt_idx),
      .any_o     (any_req)
   );

   assign can_load = (state_q == OUT_EMPTY) || bus.wb_ready;
   assign grant    = can_load && !bus.flush && any_req && !rst;
   // Writes to x0 without an error have no architectural effect.
   assign drop     = (bus.unit_rd[gnt_idx] == '0) && !bus.unit_error[gnt_idx];

   assign bus.unit_clear = grant ? gnt : '0;

   always_comb begin
      state_d = state_q;
      pkt_d   = pkt_q;
      ptr_d   = ptr_q;
      if (bus.flush) begin
         state_d = OUT_EMPTY;
      end else if (grant) begin
         ptr_d = (gnt_idx == SRC_W'(N_UNITS - 1)) ? '0 : gnt_idx + 1'b1;
         if (drop) begin
            state_d = OUT_EMPTY;
         end else begin
            state_d = OUT_FULL;
            pkt_d   = '{data:  bus.unit_res[gnt_idx],
                        rd:    bus.unit_rd[gnt_idx],
                        error: bus.unit_error[gnt_idx],
                        src:   SRC_MAX_W'(gnt_idx)};
         end
      end else if (can_load) begin
         state_d = OUT_EMPTY;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= OUT_EMPTY;
         pkt_q   <= '0;
         ptr_q   <= '0;
      end else begin
         state_q <= state_d;
         pkt_q   <= pkt_d;
         ptr_q   <= ptr_d;
      end
   end

   assign bus.wb_valid = (state_q == OUT_FULL);
   assign bus.wb_data  = pkt_q.data;
   assign bus.wb_rd    = pkt_q.rd;
   assign bus.wb_error = pkt_q.error;
   assign bus.wb_src   = SRC_W'(pkt_q.src);
   assign dbg_state_o  = state_q;
endmodule
